// File: rtl/bp_common_pkg.sv
// Shared config-bus definitions: loader states, config register map and bus packet.
package bp_common_pkg;

  typedef enum logic [3:0] {
    e_reset,
    e_freeze,
    e_core_id,
    e_fetch,
    e_ucode_lo,
    e_ucode_hi,
    e_mode,
    e_unfreeze,
    e_done
  } bp_cfg_loader_state_e;

  localparam logic [15:0] bp_cfg_addr_freeze_gp      = 16'h0001;
  localparam logic [15:0] bp_cfg_addr_core_id_gp     = 16'h0002;
  localparam logic [15:0] bp_cfg_addr_cce_mode_gp    = 16'h0003;
  localparam logic [15:0] bp_cfg_addr_ucode_base_gp  = 16'h8000;

  typedef struct packed {
    logic [7:0]  core;
    logic [15:0] addr;
    logic [31:0] data;
  } bp_cfg_bus_s;

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up-counter with synchronous clear; clear wins over increment.
module bsg_counter_clear_up #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_o
);

  always_ff @(posedge clk_i) begin
    if (reset_i)
      count_o <= '0;
    else if (clear_i)
      count_o <= '0;
    else if (up_i)
      count_o <= count_o + width_p'(1);
  end

endmodule

// File: rtl/bp_cfg_loader.sv
// Boot-time config sequencer: freeze, core id, microcode load, mode, unfreeze per core.
// BP_CFG_LOADER_UCODE_EN enables the microcode load; without it cores boot in uncached mode.
module bp_cfg_loader
  import bp_common_pkg::*;
#(
  parameter int num_core_p              = 1,
  parameter int cfg_core_width_p        = 8,
  parameter int cfg_addr_width_p        = 16,
  parameter int cfg_data_width_p        = 32,
  parameter int num_cce_instr_ram_els_p = 256,
  parameter int cce_instr_width_p       = 64,
  localparam int core_cnt_width_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1,
  localparam int rom_addr_width_lp =
    (num_cce_instr_ram_els_p > 1) ? $clog2(num_cce_instr_ram_els_p) : 1
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  output logic                         cfg_v_o,
  input  logic                         cfg_ready_i,
  output logic [cfg_core_width_p-1:0]  cfg_core_o,
  output logic [cfg_addr_width_p-1:0]  cfg_addr_o,
  output logic [cfg_data_width_p-1:0]  cfg_data_o,
  output logic [rom_addr_width_lp-1:0] rom_addr_o,
  input  logic [cce_instr_width_p-1:0] rom_data_i,
  output logic                         done_o
);

  if (cce_instr_width_p != 2 * cfg_data_width_p) begin : g_instr_width_check
    $error("cce_instr_width_p must be twice cfg_data_width_p");
  end
  if (num_cce_instr_ram_els_p > 16384) begin : g_ucode_size_check
    $error("microcode does not fit the config address space above the ucode base");
  end

  bp_cfg_loader_state_e state_r;
  logic cfg_v_r, done_r;
  logic hs;

  logic [core_cnt_width_lp-1:0] core_cnt;
  logic core_clear, core_up, last_core;

  assign cfg_v_o = cfg_v_r;
  assign done_o  = done_r;
  assign hs      = cfg_v_r & cfg_ready_i;

  assign last_core  = (core_cnt == core_cnt_width_lp'(num_core_p - 1));
  assign core_clear = (state_r == e_reset);
  assign core_up    = hs & (state_r == e_unfreeze) & ~last_core;

  bsg_counter_clear_up #(
    .width_p(core_cnt_width_lp)
  ) core_counter (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (core_clear),
    .up_i    (core_up),
    .count_o (core_cnt)
  );

`ifdef BP_CFG_LOADER_UCODE_EN
  localparam logic cce_mode_lp = 1'b1;

  logic [rom_addr_width_lp-1:0] instr_cnt;
  logic instr_clear, instr_up, last_instr;

  assign last_instr  = (instr_cnt == rom_addr_width_lp'(num_cce_instr_ram_els_p - 1));
  assign instr_clear = (state_r == e_reset) | (hs & (state_r == e_ucode_hi) & last_instr);
  assign instr_up    = hs & (state_r == e_ucode_hi) & ~last_instr;

  bsg_counter_clear_up #(
    .width_p(rom_addr_width_lp)
  ) instr_counter (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (instr_clear),
    .up_i    (instr_up),
    .count_o (instr_cnt)
  );

  // Address held on instr_cnt in every state keeps ROM data valid across stalls.
  assign rom_addr_o = instr_cnt;
`else
  localparam logic cce_mode_lp = 1'b0;

  logic unused_rom_data;
  assign unused_rom_data = ^rom_data_i;
  assign rom_addr_o      = '0;
`endif

  // Valid and done are registered from the next state, so ready never reaches valid.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= e_reset;
      cfg_v_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        e_reset: begin
          state_r <= e_freeze;
          cfg_v_r <= 1'b1;
        end
        e_freeze: begin
          if (hs) state_r <= e_core_id;
        end
        e_core_id: begin
          if (hs) begin
`ifdef BP_CFG_LOADER_UCODE_EN
            state_r <= e_fetch;
            cfg_v_r <= 1'b0;
`else
            state_r <= e_mode;
`endif
          end
        end
`ifdef BP_CFG_LOADER_UCODE_EN
        e_fetch: begin
          state_r <= e_ucode_lo;
          cfg_v_r <= 1'b1;
        end
        e_ucode_lo: begin
          if (hs) state_r <= e_ucode_hi;
        end
        e_ucode_hi: begin
          if (hs) begin
            if (last_instr) begin
              state_r <= e_mode;
            end else begin
              state_r <= e_fetch;
              cfg_v_r <= 1'b0;
            end
          end
        end
`endif
        e_mode: begin
          if (hs) state_r <= e_unfreeze;
        end
        e_unfreeze: begin
          if (hs) begin
            if (last_core) begin
              state_r <= e_done;
              cfg_v_r <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              state_r <= e_freeze;
            end
          end
        end
        e_done: begin
          cfg_v_r <= 1'b0;
          done_r  <= 1'b1;
        end
        default: begin
          state_r <= e_reset;
          cfg_v_r <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_core_o = cfg_core_width_p'(core_cnt);

  always_comb begin
    cfg_addr_o = '0;
    cfg_data_o = '0;
    case (state_r)
      e_freeze: begin
        cfg_addr_o = cfg_addr_width_p'(bp_cfg_addr_freeze_gp);
        cfg_data_o = cfg_data_width_p'(1'b1);
      end
      e_core_id: begin
        cfg_addr_o = cfg_addr_width_p'(bp_cfg_addr_core_id_gp);
        cfg_data_o = cfg_data_width_p'(core_cnt);
      end
`ifdef BP_CFG_LOADER_UCODE_EN
      e_ucode_lo: begin
        cfg_addr_o = cfg_addr_width_p'(bp_cfg_addr_ucode_base_gp)
                   + cfg_addr_width_p'({instr_cnt, 1'b0});
        cfg_data_o = rom_data_i[cfg_data_width_p-1:0];
      end
      e_ucode_hi: begin
        cfg_addr_o = cfg_addr_width_p'(bp_cfg_addr_ucode_base_gp)
                   + cfg_addr_width_p'({instr_cnt, 1'b1});
        cfg_data_o = rom_data_i[2*cfg_data_width_p-1:cfg_data_width_p];
      end
`endif
      e_mode: begin
        cfg_addr_o = cfg_addr_width_p'(bp_cfg_addr_cce_mode_gp);
        cfg_data_o = cfg_data_width_p'(cce_mode_lp);
      end
      e_unfreeze: begin
        cfg_addr_o = cfg_addr_width_p'(bp_cfg_addr_freeze_gp);
        cfg_data_o = '0;
      end
      default: begin
        cfg_addr_o = '0;
        cfg_data_o = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_bp_cfg_loader.sv
// Self-checking bench for bp_cfg_loader: two cores, eight microcode entries, random ROM.
module tb_bp_cfg_loader;
  import bp_common_pkg::*;

  localparam int C = 2;
  localparam int N = 8;
`ifdef BP_CFG_LOADER_UCODE_EN
  localparam int UCODE = 1;
`else
  localparam int UCODE = 0;
`endif
  localparam int EXP_DONE = UCODE ? 1 + C * (4 + 3 * N) : 1 + C * 4;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        cfg_ready_i = 1'b0;
  logic        cfg_v_o;
  logic [7:0]  cfg_core_o;
  logic [15:0] cfg_addr_o;
  logic [31:0] cfg_data_o;
  logic [2:0]  rom_addr_o;
  logic [63:0] rom_data_i = '0;
  logic        done_o;

  logic [63:0]  rom [N];
  bp_cfg_bus_s  log_q [$];
  bp_cfg_bus_s  exp_q [$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bp_cfg_loader #(
    .num_core_p              (C),
    .cfg_core_width_p        (8),
    .cfg_addr_width_p        (16),
    .cfg_data_width_p        (32),
    .num_cce_instr_ram_els_p (N),
    .cce_instr_width_p       (64)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .cfg_v_o     (cfg_v_o),
    .cfg_ready_i (cfg_ready_i),
    .cfg_core_o  (cfg_core_o),
    .cfg_addr_o  (cfg_addr_o),
    .cfg_data_o  (cfg_data_o),
    .rom_addr_o  (rom_addr_o),
    .rom_data_i  (rom_data_i),
    .done_o      (done_o)
  );

  // Synchronous ROM and config endpoint models.
  always @(posedge clk) rom_data_i <= rom[rom_addr_o];

  always @(posedge clk)
    if (!reset_i && cfg_v_o && cfg_ready_i)
      log_q.push_back(bp_cfg_bus_s'{cfg_core_o, cfg_addr_o, cfg_data_o});

  task automatic load_rom();
    for (int i = 0; i < N; i++) rom[i] = {$urandom, $urandom};
  endtask

  // Expected write stream derived directly from the per-core boot recipe.
  task automatic build_expected();
    exp_q.delete();
    for (int c = 0; c < C; c++) begin
      exp_q.push_back(bp_cfg_bus_s'{8'(c), 16'h0001, 32'd1});
      exp_q.push_back(bp_cfg_bus_s'{8'(c), 16'h0002, 32'(c)});
      if (UCODE != 0)
        for (int i = 0; i < N; i++) begin
          exp_q.push_back(bp_cfg_bus_s'{8'(c), 16'(16'h8000 + 2 * i), rom[i][31:0]});
          exp_q.push_back(bp_cfg_bus_s'{8'(c), 16'(16'h8000 + 2 * i + 1), rom[i][63:32]});
        end
      exp_q.push_back(bp_cfg_bus_s'{8'(c), 16'h0003, 32'(UCODE)});
      exp_q.push_back(bp_cfg_bus_s'{8'(c), 16'h0001, 32'd0});
    end
  endtask

  function automatic int first_diff();
    int n;
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (log_q[i] !== exp_q[i]) return i;
    if (log_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  // Leaves the bench at the negedge of cycle 0 (first cycle with reset low).
  task automatic do_reset();
    @(negedge clk);
    reset_i = 1'b1;
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
    log_q.delete();
  endtask

  task automatic test_reset();
    cfg_ready_i = 1'b1;
    reset_i = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (cfg_v_o !== 1'b0) begin n_err++; $display("FAIL reset_v got %b want 0", cfg_v_o); end
    n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done_o); end
    n_cmp++; if (cfg_core_o !== 8'd0) begin n_err++; $display("FAIL reset_core got %0h want 0", cfg_core_o); end
    n_cmp++; if (cfg_addr_o !== 16'd0) begin n_err++; $display("FAIL reset_addr got %0h want 0", cfg_addr_o); end
    n_cmp++; if (cfg_data_o !== 32'd0) begin n_err++; $display("FAIL reset_data got %0h want 0", cfg_data_o); end
    n_cmp++; if (rom_addr_o !== 3'd0) begin n_err++; $display("FAIL reset_rom_addr got %0h want 0", rom_addr_o); end
    reset_i = 1'b0;
    n_cmp++; if (cfg_v_o !== 1'b0) begin n_err++; $display("FAIL cycle0_v got %b want 0", cfg_v_o); end
    @(negedge clk);
    n_cmp++;
    if (cfg_v_o !== 1'b1 || cfg_addr_o !== 16'h0001 || cfg_data_o !== 32'd1 || cfg_core_o !== 8'd0) begin
      n_err++;
      $display("FAIL cycle1_freeze got v=%b addr=%0h data=%0h core=%0h want v=1 addr=1 data=1 core=0",
               cfg_v_o, cfg_addr_o, cfg_data_o, cfg_core_o);
    end
  endtask

  task automatic test_ready_high();
    int cycles, d;
    load_rom();
    build_expected();
    cfg_ready_i = 1'b1;
    do_reset();
    cycles = 0;
    while (!done_o && cycles < 500) begin
      @(negedge clk);
      cycles++;
`ifndef BP_CFG_LOADER_UCODE_EN
      n_cmp++; if (rom_addr_o !== 3'd0) begin n_err++; $display("FAIL rom_addr_tied got %0h want 0", rom_addr_o); end
`endif
    end
    n_cmp++; if (cycles !== EXP_DONE) begin n_err++; $display("FAIL ready_high_done_cycle got %0d want %0d", cycles, EXP_DONE); end
    d = first_diff();
    n_cmp++;
    if (d != -1) begin
      n_err++;
      $display("FAIL ready_high_writes first diff at %0d, got %0d writes want %0d", d, log_q.size(), exp_q.size());
    end
    repeat (5) begin
      @(negedge clk);
      n_cmp++;
      if (done_o !== 1'b1 || cfg_v_o !== 1'b0) begin
        n_err++; $display("FAIL done_sticky got done=%b v=%b want done=1 v=0", done_o, cfg_v_o);
      end
    end
  endtask

  task automatic test_stall();
    int cycles, d;
    bit found;
    logic [15:0] target, a_hold;
    logic [31:0] d_hold, d_exp;
    logic [7:0]  c_hold;
    load_rom();
    build_expected();
    target = (UCODE != 0) ? 16'h8001 : 16'h0003;
    d_exp  = (UCODE != 0) ? rom[0][63:32] : 32'd0;
    cfg_ready_i = 1'b1;
    do_reset();
    cycles = 0;
    found = 1'b0;
    while (!found && cycles < 500) begin
      @(negedge clk);
      cycles++;
      if (cfg_v_o && cfg_addr_o == target) found = 1'b1;
    end
    cfg_ready_i = 1'b0;
    n_cmp++; if (found !== 1'b1) begin n_err++; $display("FAIL stall_target_seen got 0 want 1"); end
    n_cmp++; if (cfg_data_o !== d_exp) begin n_err++; $display("FAIL stall_data got %0h want %0h", cfg_data_o, d_exp); end
    a_hold = cfg_addr_o;
    d_hold = cfg_data_o;
    c_hold = cfg_core_o;
    repeat (5) begin
      @(negedge clk);
      cycles++;
      n_cmp++;
      if (cfg_v_o !== 1'b1 || cfg_addr_o !== a_hold || cfg_data_o !== d_hold || cfg_core_o !== c_hold) begin
        n_err++;
        $display("FAIL stall_hold got v=%b addr=%0h data=%0h core=%0h want v=1 addr=%0h data=%0h core=%0h",
                 cfg_v_o, cfg_addr_o, cfg_data_o, cfg_core_o, a_hold, d_hold, c_hold);
      end
    end
    cfg_ready_i = 1'b1;
    while (!done_o && cycles < 500) begin
      @(negedge clk);
      cycles++;
    end
    n_cmp++; if (cycles !== EXP_DONE + 5) begin n_err++; $display("FAIL stall_done_cycle got %0d want %0d", cycles, EXP_DONE + 5); end
    d = first_diff();
    n_cmp++;
    if (d != -1) begin
      n_err++;
      $display("FAIL stall_writes first diff at %0d, got %0d writes want %0d", d, log_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int cycles, d;
    bit found;
    logic [15:0] target;
    logic [7:0]  tcore;
    load_rom();
    build_expected();
    target = (UCODE != 0) ? 16'h8004 : 16'h0002;
    tcore  = (UCODE != 0) ? 8'd0 : 8'd1;
    cfg_ready_i = 1'b1;
    do_reset();
    cycles = 0;
    found = 1'b0;
    while (!found && cycles < 500) begin
      @(negedge clk);
      cycles++;
      if (cfg_v_o && cfg_addr_o == target && cfg_core_o == tcore) found = 1'b1;
    end
    n_cmp++; if (found !== 1'b1) begin n_err++; $display("FAIL midreset_target_seen got 0 want 1"); end
    reset_i = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (cfg_v_o !== 1'b0 || cfg_addr_o !== 16'd0 || cfg_core_o !== 8'd0 || done_o !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_outputs got v=%b addr=%0h core=%0h done=%b want all 0",
               cfg_v_o, cfg_addr_o, cfg_core_o, done_o);
    end
    reset_i = 1'b0;
    log_q.delete();
    cycles = 0;
    while (!done_o && cycles < 500) begin
      @(negedge clk);
      cycles++;
    end
    n_cmp++; if (cycles !== EXP_DONE) begin n_err++; $display("FAIL midreset_done_cycle got %0d want %0d", cycles, EXP_DONE); end
    d = first_diff();
    n_cmp++;
    if (d != -1) begin
      n_err++;
      $display("FAIL midreset_writes first diff at %0d, got %0d writes want %0d", d, log_q.size(), exp_q.size());
    end
  endtask

  task automatic test_random_ready();
    int cycles, d;
    bit stalled;
    logic [15:0] a_hold;
    logic [31:0] d_hold;
    logic [7:0]  c_hold;
    load_rom();
    build_expected();
    cfg_ready_i = 1'b0;
    do_reset();
    cycles = 0;
    stalled = 1'b0;
    a_hold = '0; d_hold = '0; c_hold = '0;
    while (!done_o && cycles < 2000) begin
      cfg_ready_i = 1'($urandom_range(0, 1));
      stalled = cfg_v_o && !cfg_ready_i;
      a_hold = cfg_addr_o;
      d_hold = cfg_data_o;
      c_hold = cfg_core_o;
      @(negedge clk);
      cycles++;
      if (stalled) begin
        n_cmp++;
        if (cfg_v_o !== 1'b1 || cfg_addr_o !== a_hold || cfg_data_o !== d_hold || cfg_core_o !== c_hold) begin
          n_err++;
          $display("FAIL random_hold got v=%b addr=%0h data=%0h want v=1 addr=%0h data=%0h",
                   cfg_v_o, cfg_addr_o, cfg_data_o, a_hold, d_hold);
        end
      end
    end
    n_cmp++; if (done_o !== 1'b1) begin n_err++; $display("FAIL random_done got %b want 1", done_o); end
    n_cmp++; if (cycles < EXP_DONE) begin n_err++; $display("FAIL random_min_cycles got %0d want >= %0d", cycles, EXP_DONE); end
    d = first_diff();
    n_cmp++;
    if (d != -1) begin
      n_err++;
      $display("FAIL random_writes first diff at %0d, got %0d writes want %0d", d, log_q.size(), exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_ready_high();
    test_stall();
    test_reset_mid();
    test_random_ready();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bp_cfg_loader.md
# bp_cfg_loader

Boot-time configuration sequencer that drives the processor config bus after reset. For each core in turn it:
- freezes the core,
- writes its core ID,
- streams the CCE microcode from a synchronous instruction ROM into the CCE instruction RAM,
- sets the CCE mode,
- unfreezes the core.

It sits between the testbench/SoC ROM and the per-core config-bus endpoints. It raises `done_o` once every core is released.

## Interface
Parameters:
- `num_core_p`, 1: number of cores to configure.
- `cfg_core_width_p`, 8: config bus core-select width.
- `cfg_addr_width_p`, 16: config bus address width.
- `cfg_data_width_p`, 32: config bus data width.
- `num_cce_instr_ram_els_p`, 256: microcode entries per CCE.
- `cce_instr_width_p`, 64: ROM word width; must equal 2*`cfg_data_width_p`.

Ports:
- `clk_i`  in  1  single clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `cfg_v_o`  out  1  config write valid.
- `cfg_ready_i`  in  1  endpoint accepts the write this cycle.
- `cfg_core_o`  out  `cfg_core_width_p`  target core index.
- `cfg_addr_o`  out  `cfg_addr_width_p`  config register address.
- `cfg_data_o`  out  `cfg_data_width_p`  write data.
- `rom_addr_o`  out  clog2(`num_cce_instr_ram_els_p`)  microcode ROM address.
- `rom_data_i`  in  `cce_instr_width_p`  ROM data; 1-cycle read latency; re-read every cycle.
- `done_o`  out  1  all cores configured; sticky until reset.

## Operation
- States: `e_reset`, `e_freeze`, `e_core_id`, `e_fetch`, `e_ucode_lo`, `e_ucode_hi`, `e_mode`, `e_unfreeze`, `e_done`.
- Counters: `core_cnt` (0..`num_core_p`-1) and `instr_cnt` (0..`num_cce_instr_ram_els_p`-1).
- `e_reset`:
  - always one cycle;
  - clears both counters;
  - goes to `e_freeze`.
- Config-write states and the write each one issues:
  - `e_freeze`: addr `bp_cfg_addr_freeze_gp` (0x0001), data 1.
  - `e_core_id`: addr `bp_cfg_addr_core_id_gp` (0x0002), data = `core_cnt` zero-extended.
  - `e_ucode_lo`: addr `bp_cfg_addr_ucode_base_gp` (0x8000) + 2*`instr_cnt`, data = `rom_data_i[31:0]`.
  - `e_ucode_hi`: addr 0x8000 + 2*`instr_cnt` + 1, data = `rom_data_i[63:32]`.
  - `e_mode`: addr `bp_cfg_addr_cce_mode_gp` (0x0003), data 1 (normal mode).
  - `e_unfreeze`: addr 0x0001, data 0.
- In every config-write state, `cfg_core_o` = `core_cnt`.
- `e_fetch`:
  - `cfg_v_o` = 0;
  - presents `rom_addr_o` = `instr_cnt`;
  - always lasts one cycle;
  - goes to `e_ucode_lo`.
- `rom_addr_o` holds `instr_cnt` in every state, so ROM data stays valid through `e_ucode_lo` and `e_ucode_hi` across stalls.
- State advances only on a handshake (`cfg_v_o` & `cfg_ready_i`). Transitions on handshake:
  - freeze → core_id → fetch.
  - ucode_lo → ucode_hi.
  - ucode_hi → fetch with `instr_cnt`+1, or → mode if `instr_cnt` is the last entry (`instr_cnt` cleared).
  - mode → unfreeze.
  - unfreeze → freeze with `core_cnt`+1, or → done if `core_cnt` is the last core.
- `e_done`:
  - `cfg_v_o` = 0, `done_o` = 1;
  - terminal state.
- The ucode address fits the address bus when `num_cce_instr_ram_els_p` ≤ 16384; elaboration asserts this and `cce_instr_width_p` == 2*`cfg_data_width_p`.

## Timing
- Reset values: `cfg_v_o`=0, `done_o`=0, `cfg_core_o`/`cfg_addr_o`/`cfg_data_o`/`rom_addr_o`=0; state = `e_reset`.
- `cfg_v_o` is decoded from state only; there is no combinational path from `cfg_ready_i` to `cfg_v_o`.
- While `cfg_v_o`=1 and `cfg_ready_i`=0:
  - core, addr and data are held stable;
  - valid is never dropped before the handshake.
- Cycle count with `cfg_ready_i` tied high, first cycle after reset deasserts = cycle 0:
  - per core: 4 + 3N cycles;
  - `done_o` rises at cycle 1 + C*(4+3N).
- Reset asserted mid-operation:
  - next cycle `cfg_v_o`=0 and state = `e_reset`;
  - counters cleared;
  - the sequence restarts from core 0.
- A handshake on the cycle reset is asserted is ignored.

## Configuration
- Macro `BP_CFG_LOADER_UCODE_EN`.
- Defined:
  - full sequence as above;
  - `e_mode` writes 1.
- Undefined:
  - `e_fetch`, `e_ucode_lo` and `e_ucode_hi` are compiled out; core_id goes directly to mode;
  - `e_mode` writes 0 (CCE uncached mode);
  - `rom_addr_o` tied 0;
  - `rom_data_i` unused;
  - per-core latency is 4 cycles.

## Structure
- Shared package `bp_common_pkg` holds:
  - the state enum `bp_cfg_loader_state_e`;
  - the address constants `bp_cfg_addr_freeze_gp`, `bp_cfg_addr_core_id_gp`, `bp_cfg_addr_cce_mode_gp`, `bp_cfg_addr_ucode_base_gp`;
  - the config-bus packet struct `bp_cfg_bus_s` (core, addr, data).
- Sub-module: `bsg_counter_clear_up` instances for `core_cnt` and `instr_cnt`. The FSM stays in the top module.

## Test plan
- C=1, N=4, ready=1 → writes in order (0x0001,1), (0x0002,0), eight ucode writes 0x8000–0x8007 carrying ROM lo/hi halves, (0x0003,1), (0x0001,0); `done_o` high at cycle 17.
- C=2, N=2 → core 0 sequence fully precedes core 1; core 1 ID write carries data 1 with `cfg_core_o`=1; `done_o` at cycle 21.
- `cfg_ready_i` low for 5 cycles during `e_ucode_hi` → addr, data and valid held stable; after release, write 0x8001 is accepted once, no duplicate.
- Reset pulsed during the third ucode entry → `cfg_v_o`=0 next cycle; sequence restarts with the freeze write to core 0.
- Macro undefined, C=2 → per core only freeze, ID, mode=0, unfreeze; `rom_addr_o` stays 0; `done_o` at cycle 9.
- Random `cfg_ready_i` (50%), C=2, N=8 → endpoint model's RAM contents match the ROM; exactly 1 + 2*(4+3*8) = 57 handshakes-or-internal steps complete with no lost or repeated write.
